// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared core types and constants used by the fetch stage
//
// Purpose: core-wide package. Holds the reset PC default, the NOP encoding,
//          the fetch buffer entry type and the decode/ALU enumerations shared
//          with later pipeline stages.
// Ports:   none (package).
package instruction_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [3:0] {
    OP,
    OPIMM,
    BRANCH,
    LUI,
    JAL,
    JALR,
    LOAD,
    STORE,
    AUIPC,
    UNSUPPORTED
  } Itype;

  typedef enum logic [3:0] {
    ADD,
    SUB,
    AND,
    OR,
    XOR,
    SLT,
    SLTU,
    SLL,
    SRL,
    SRA
  } AluFunc;

  // Word-align a byte address; the low two bits are simply dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction buffer between BRAM responses and decode
//
// Purpose: DEPTH-entry synchronous FIFO of fetch_entry_t. Push and pop may
//          happen in the same cycle (including when full); flush empties it.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   flush      discard all entries this cycle (wins over push)
//   push       write push_entry (accepted when not full, or when popping)
//   push_entry entry to write
//   pop        remove head (ignored when empty)
//   head       current head entry (contents undefined when empty)
//   full       count == DEPTH
//   empty      count == 0
//   count      number of valid entries
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);

  // A full buffer can still take a write when the head leaves the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - in-order instruction fetch with BRAM tag pipeline and redirect epochs
//
// Purpose: issues one instruction-memory read per cycle while the buffer has
//          room for everything already in flight, matches BRAM responses with
//          their PCs through a latency-deep tag pipeline, and hands
//          instructions to decode through fetch_fifo with a valid/ready handshake.
//          A redirect flushes buffered and in-flight work and restarts at the
//          new PC the following cycle.
// Ports:
//   clk_in             clock, rising edge
//   rst_in             synchronous active-high reset (overrides redirect)
//   redirect_valid_in  change PC this cycle
//   redirect_pc_in     new byte PC (low two bits ignored)
//   imem_en_out        BRAM read strobe
//   imem_addr_out      BRAM word address (fetch pc[IMEM_ADDR_W+1:2])
//   imem_data_in       BRAM read data, IMEM_LATENCY cycles after the strobe
//   inst_valid_out     inst_out/pc_out valid
//   inst_ready_in      decode accepts this cycle
//   inst_out           instruction word (NOP when not valid)
//   pc_out             byte PC of inst_out (0 when not valid)
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int          IMEM_ADDR_W  = 12,
  parameter int          IMEM_LATENCY = 2,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   redirect_valid_in,
  input  logic [31:0]            redirect_pc_in,
  output logic                   imem_en_out,
  output logic [IMEM_ADDR_W-1:0] imem_addr_out,
  input  logic [31:0]            imem_data_in,
  output logic                   inst_valid_out,
  input  logic                   inst_ready_in,
  output logic [31:0]            inst_out,
  output logic [31:0]            pc_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]             fetch_pc;
  logic                    epoch;

  logic [IMEM_LATENCY-1:0] tag_valid;
  logic [IMEM_LATENCY-1:0] tag_epoch;
  logic [31:0]             tag_pc [IMEM_LATENCY];

  logic [CNT_W-1:0]        in_flight;
  logic [CNT_W:0]          occupancy;
  logic                    room;
  logic                    issue;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  fetch_entry_t            fifo_head;
  fetch_entry_t            resp_entry;

  // Reads in flight each reserve a buffer slot, so a response always has
  // somewhere to land and the BRAM never needs to be stalled.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < IMEM_LATENCY; i++) begin
      in_flight = in_flight + CNT_W'(tag_valid[i]);
    end
  end

  assign occupancy = {1'b0, fifo_count} + {1'b0, in_flight};
  assign room      = !fifo_full && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign issue     = !rst_in && !redirect_valid_in && room;

  assign imem_en_out   = issue;
  assign imem_addr_out = fetch_pc[IMEM_ADDR_W+1:2];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_pc <= RESET_PC;
      epoch    <= 1'b0;
    end else if (redirect_valid_in) begin
      fetch_pc <= align_pc(redirect_pc_in);
      epoch    <= ~epoch;
    end else if (issue) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Redirect also clears the valid bits outright. The epoch check below then
  // only matters as a second guard, but it keeps back-to-back redirects safe
  // even when the 1-bit epoch would otherwise alias across two toggles.
  always_ff @(posedge clk_in) begin
    if (rst_in || redirect_valid_in) begin
      tag_valid <= '0;
    end else begin
      tag_valid[0] <= issue;
      for (int i = 1; i < IMEM_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    tag_pc[0]    <= fetch_pc;
    tag_epoch[0] <= epoch;
    for (int i = 1; i < IMEM_LATENCY; i++) begin
      tag_pc[i]    <= tag_pc[i-1];
      tag_epoch[i] <= tag_epoch[i-1];
    end
  end

  // The last tag stage lines up with the cycle the BRAM data is valid.
  assign resp_entry.pc   = tag_pc[IMEM_LATENCY-1];
  assign resp_entry.inst = imem_data_in;
  assign fifo_push = tag_valid[IMEM_LATENCY-1]
                  && (tag_epoch[IMEM_LATENCY-1] == epoch)
                  && !redirect_valid_in;

  assign inst_valid_out = !fifo_empty && !rst_in;
  assign fifo_pop       = inst_valid_out && inst_ready_in;
  assign inst_out       = inst_valid_out ? fifo_head.inst : NOP_INST;
  assign pc_out         = inst_valid_out ? fifo_head.pc   : 32'h0000_0000;

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk        (clk_in),
    .rst        (rst_in),
    .flush      (redirect_valid_in),
    .push       (fifo_push),
    .push_entry (resp_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int LAT   = 2;
  localparam int AW    = 12;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          redirect_valid_in;
  logic [31:0]   redirect_pc_in;
  logic          imem_en_out;
  logic [AW-1:0] imem_addr_out;
  logic [31:0]   imem_data_in;
  logic          inst_valid_out;
  logic          inst_ready_in;
  logic [31:0]   inst_out;
  logic [31:0]   pc_out;

  always #5 clk_in = ~clk_in;

  instruction_fetch #(
    .RESET_PC     (RPC),
    .IMEM_ADDR_W  (AW),
    .IMEM_LATENCY (LAT),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .redirect_valid_in (redirect_valid_in),
    .redirect_pc_in    (redirect_pc_in),
    .imem_en_out       (imem_en_out),
    .imem_addr_out     (imem_addr_out),
    .imem_data_in      (imem_data_in),
    .inst_valid_out    (inst_valid_out),
    .inst_ready_in     (inst_ready_in),
    .inst_out          (inst_out),
    .pc_out            (pc_out)
  );

  // Instruction memory: word i holds i; read data appears LAT cycles after the strobe.
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk_in) begin
    rd_pipe[0] <= imem_en_out ? {{(32-AW){1'b0}}, imem_addr_out} : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign imem_data_in = rd_pipe[LAT-1];

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {{(32-AW){1'b0}}, pc[AW+1:2]};
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observations of the current cycle and reference-model state.
  logic [31:0] o_valid, o_pc, o_inst, o_en, o_addr;
  logic        o_hs;
  logic [31:0] exp_pc, exp_fetch;
  logic        prev_hold, prev_redirect, prev_rst;
  logic [31:0] prev_pc, prev_inst;
  int          hs_count = 0;

  task automatic cycle(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
    @(posedge clk_in);
    #1;
    rst_in            = rst;
    redirect_valid_in = redir;
    redirect_pc_in    = rpc;
    inst_ready_in     = rdy;
    @(negedge clk_in);
    o_valid = 32'(inst_valid_out);
    o_pc    = pc_out;
    o_inst  = inst_out;
    o_en    = 32'(imem_en_out);
    o_addr  = {{(32-AW){1'b0}}, imem_addr_out};
    o_hs    = inst_valid_out && rdy;
    if (rst) begin
      check_eq("rst_valid", o_valid, 32'd0);
      check_eq("rst_en", o_en, 32'd0);
      check_eq("rst_inst", o_inst, NOP_INST);
      check_eq("rst_pc", o_pc, 32'd0);
      exp_pc        = RPC;
      exp_fetch     = RPC;
      prev_hold     = 1'b0;
      prev_redirect = 1'b0;
      prev_rst      = 1'b1;
      return;
    end
    if (prev_rst || prev_redirect) check_eq("valid_after_flush", o_valid, 32'd0);
    if (prev_hold) begin
      check_eq("hold_valid", o_valid, 32'd1);
      check_eq("hold_pc", o_pc, prev_pc);
      check_eq("hold_inst", o_inst, prev_inst);
    end
    if (redir) begin
      check_eq("no_issue_on_redirect", o_en, 32'd0);
    end else if (o_en[0]) begin
      check_eq("issue_addr", o_addr, word_of(exp_fetch));
      exp_fetch = exp_fetch + 32'd4;
    end
    if (o_hs) begin
      check_eq("hs_pc", o_pc, exp_pc);
      check_eq("hs_inst", o_inst, word_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      hs_count++;
    end
    if (redir) begin
      exp_pc    = {rpc[31:2], 2'b00};
      exp_fetch = {rpc[31:2], 2'b00};
    end
    prev_hold     = o_valid[0] && !rdy && !redir;
    prev_pc       = o_pc;
    prev_inst     = o_inst;
    prev_redirect = redir;
    prev_rst      = 1'b0;
  endtask

  // Stream 0x0..0xC with 0x8/0xC in flight at cycle 4, redirect there while
  // the head (pc 0x4) is being accepted, then watch the restart.
  task automatic redirect_test(input string name, input logic [31:0] target,
                               input logic [31:0] exp_addr, input logic [31:0] exp_first);
    int pc4_seen;
    int stale_seen;
    int wait_cycles;
    logic found;
    pc4_seen   = 0;
    stale_seen = 0;
    found      = 1'b0;
    wait_cycles = 0;
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      if (o_hs && o_pc == 32'h4) pc4_seen++;
    end
    cycle(1'b0, 1'b1, target, 1'b1);
    check_eq({name, "_head_valid"}, o_valid, 32'd1);
    check_eq({name, "_head_pc"}, o_pc, 32'h4);
    if (o_hs && o_pc == 32'h4) pc4_seen++;
    for (int k = 0; k < 8 && !found; k++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      if (k == 0) begin
        check_eq({name, "_first_en"}, o_en, 32'd1);
        check_eq({name, "_first_addr"}, o_addr, exp_addr);
      end
      if (o_valid[0]) begin
        found = 1'b1;
        wait_cycles = k;
        check_eq({name, "_first_pc"}, o_pc, exp_first);
      end
    end
    check_eq({name, "_found"}, 32'(found), 32'd1);
    check_eq({name, "_latency"}, 32'(wait_cycles), 32'd3);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      if (o_valid[0] && (o_pc == 32'h8 || o_pc == 32'hC)) stale_seen++;
      if (o_hs && o_pc == 32'h4) pc4_seen++;
    end
    check_eq({name, "_stale"}, 32'(stale_seen), 32'd0);
    check_eq({name, "_pc4_once"}, 32'(pc4_seen), 32'd1);
  endtask

  initial begin
    int issues;
    int hs_start;
    logic [31:0] seq [$];

    rst_in            = 1'b1;
    redirect_valid_in = 1'b0;
    redirect_pc_in    = 32'd0;
    inst_ready_in     = 1'b0;
    prev_hold = 1'b0; prev_redirect = 1'b0; prev_rst = 1'b1;
    exp_pc = RPC; exp_fetch = RPC; prev_pc = 32'd0; prev_inst = 32'd0;

    // Reset then streaming with ready held high.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      if (i == 0) begin
        check_eq("stream_first_en", o_en, 32'd1);
        check_eq("stream_first_addr", o_addr, 32'(RPC >> 2));
      end
      if (i < 3) begin
        check_eq("stream_early_valid", o_valid, 32'd0);
      end else begin
        check_eq("stream_valid", o_valid, 32'd1);
        check_eq("stream_pc", o_pc, 32'(4 * (i - 3)));
        check_eq("stream_inst", o_inst, 32'(i - 3));
      end
    end

    // Backpressure: fill, stop issuing, then drain in order.
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      issues += int'(o_en[0]);
      if (i == 9) check_eq("bp_en_when_full", o_en, 32'd0);
    end
    check_eq("bp_issue_count", 32'(issues), 32'(DEPTH));
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      check_eq("bp_drain_valid", o_valid, 32'd1);
      check_eq("bp_drain_pc", o_pc, 32'(4 * i));
    end

    // Redirects with reads in flight, misaligned target, same-cycle handshake.
    redirect_test("redir100", 32'h0000_0100, 32'h40, 32'h100);
    redirect_test("redir103", 32'h0000_0103, 32'h40, 32'h100);
    redirect_test("redir200", 32'h0000_0200, 32'h80, 32'h200);

    // PC wrap at the top of the address space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    seq.delete();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      if (o_hs) seq.push_back(o_pc);
    end
    check_eq("wrap_count_ge4", 32'(seq.size() >= 4), 32'd1);
    if (seq.size() >= 4) begin
      check_eq("wrap_pc0", seq[0], 32'hFFFF_FFF8);
      check_eq("wrap_pc1", seq[1], 32'hFFFF_FFFC);
      check_eq("wrap_pc2", seq[2], 32'h0000_0000);
      check_eq("wrap_pc3", seq[3], 32'h0000_0004);
    end

    // Reset mid-stream with the buffer full.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    check_eq("midrst_full_valid", o_valid, 32'd1);
    cycle(1'b1, 1'b1, 32'h0000_0400, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      if (i < 3) check_eq("midrst_valid_low", o_valid, 32'd0);
      else begin
        check_eq("midrst_valid", o_valid, 32'd1);
        check_eq("midrst_pc", o_pc, 32'd0);
      end
    end

    // Randomized traffic against the program-order model.
    hs_start = hs_count;
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_redir, r_rdy;
      logic [31:0] r_pc;
      r_rst   = ($urandom % 300) == 0;
      r_redir = ($urandom % 40) == 0;
      r_rdy   = ($urandom % 10) < 7;
      r_pc    = $urandom;
      cycle(r_rst, r_redir, r_pc, r_rdy);
    end
    check_eq("random_progress", 32'((hs_count - hs_start) > 1000), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
